// File: rtl/alu_pkg.sv
// Shared encodings and default sizes for the registered operand selector.
// Also holds a small helper that sizes counters safely.
package alu_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int DEF_WIDTH    = 6;
   localparam int DEF_N_CH     = 4;
   localparam int DEF_SCAN_DIV = 16;

   // A divide-by-1 counter still needs one bit of storage.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_counter.sv
// Round-robin channel counter for display scanning.
// Advances the channel once every SCAN_DIV enabled cycles and can be reloaded on demand.
module scan_counter
   import alu_pkg::*;
#(
   parameter  int SCAN_DIV = DEF_SCAN_DIV,
   parameter  int N_CH     = DEF_N_CH,
   localparam int SEL_W    = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic [SEL_W-1:0] restart_val,
   output logic [SEL_W-1:0] scan_ch
);

   localparam int               DIV_W    = cnt_w(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);

   logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
   logic [SEL_W-1:0] scan_ch_d, scan_ch_q;

   // Restart wins over counting so a fresh scan always begins at the reload value.
   always_comb begin
      div_cnt_d = div_cnt_q;
      scan_ch_d = scan_ch_q;
      if (restart) begin
         div_cnt_d = '0;
         scan_ch_d = restart_val;
      end else if (en) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            scan_ch_d = (scan_ch_q == CH_LAST) ? '0 : scan_ch_q + 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         scan_ch_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         scan_ch_q <= scan_ch_d;
      end
   end

   assign scan_ch = scan_ch_q;

endmodule

// File: rtl/mux_nx1_sel_reg.sv
// N-to-1 registered operand selector feeding the ALU or display path.
// Channel comes from a latched select register (DIRECT) or a round-robin scanner (SCAN).
module mux_nx1_sel_reg
   import alu_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int N_CH     = DEF_N_CH,
   parameter  int SCAN_DIV = DEF_SCAN_DIV,
   localparam int SEL_W    = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  sel_load,
   input  logic [N_CH*WIDTH-1:0] din,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      y,
   output logic                  y_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      ch_out,
   output logic                  sel_err
);

   // Handshake: a word moves when valid and ready are both high on a rising edge.
   // in_ready drops only while an unconsumed y is held against a stalled consumer.

   logic             mode_d, mode_q;
   logic [SEL_W-1:0] sel_d, sel_q;
   logic [WIDTH-1:0] y_d, y_q;
   logic             y_valid_d, y_valid_q;
   logic [SEL_W-1:0] ch_out_d, ch_out_q;
   logic             sel_err_d, sel_err_q;

   logic             mode_rise;
   logic             sel_legal;
   logic [SEL_W-1:0] scan_ch;
   logic [SEL_W-1:0] active_ch;
   logic [WIDTH-1:0] ch_data;
   logic             accept;

   assign mode_rise = (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
   assign sel_legal = 32'(sel) < 32'(N_CH);
   assign active_ch = (mode == MODE_SCAN) ? scan_ch : sel_q;
   assign in_ready  = !y_valid_q || out_ready;
   assign accept    = in_valid && in_ready;

   scan_counter #(
      .SCAN_DIV (SCAN_DIV),
      .N_CH     (N_CH)
   ) u_scan (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (mode == MODE_SCAN),
      .restart     (mode_rise),
      .restart_val (sel_q),
      .scan_ch     (scan_ch)
   );

   always_comb begin
      ch_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (active_ch == SEL_W'(k)) ch_data = din[k*WIDTH +: WIDTH];
      end
   end

   // An out-of-range request is flagged and otherwise ignored; sel_q keeps the last legal value.
   always_comb begin
      mode_d    = mode;
      sel_d     = sel_q;
      sel_err_d = sel_err_q;
      if (sel_load) begin
         if (sel_legal) sel_d = sel;
         else           sel_err_d = 1'b1;
      end
   end

   always_comb begin
      y_d       = y_q;
      ch_out_d  = ch_out_q;
      y_valid_d = y_valid_q;
      if (accept) begin
         y_d       = ch_data;
         ch_out_d  = active_ch;
         y_valid_d = 1'b1;
      end else if (out_ready) begin
         y_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_DIRECT;
         sel_q     <= '0;
         sel_err_q <= 1'b0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         ch_out_q  <= '0;
      end else begin
         mode_q    <= mode_d;
         sel_q     <= sel_d;
         sel_err_q <= sel_err_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         ch_out_q  <= ch_out_d;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign ch_out  = ch_out_q;
   assign sel_err = sel_err_q;

endmodule
